// File: rtl/en_share_arbiter.sv
// Round-robin arbiter sharing one enable-gated resource among N_REQ requesters,
// with a bounded hold time per grant and a one-cycle idle gap between owners.
// Optional concurrent assertions are compiled in with EN_SHARE_ARBITER_SVA_EN.
module en_share_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam int IW1   = ID_W + 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   next_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [IW1-1:0]    idx;
    logic              found;
    logic              owner_exit;
    logic              at_limit;

    // First requesting index at or above ptr, wrapping around N_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + IW1'(i);
            if (idx >= IW1'(N_REQ)) begin
                idx = idx - IW1'(N_REQ);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

    assign owner_exit = done[gnt_id] | ~req[gnt_id];
    assign at_limit   = (cnt == CNT_W'(MAX_HOLD - 1));
    assign next_ptr   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            en      <= 1'b0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= ONE << sel;
                        gnt_id <= sel;
                        en     <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        state  <= IDLE;
                        gnt    <= '0;
                        en     <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    // A voluntary release or abandon on the last allowed cycle is not a timeout.
                    if (owner_exit || at_limit) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        en      <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        ptr     <= next_ptr;
                        timeout <= ~owner_exit;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EN_SHARE_ARBITER_SVA_EN
    logic [N_REQ-1:0] req_q;

    // Request vector as seen at the grant edge, for checking the new owner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt))
        $info("a_gnt_onehot pass at %0t", $time);
    else $error("a_gnt_onehot failed at %0t", $time);

    a_en_matches_gnt: assert property (@(posedge clk) disable iff (!rst) en == (gnt != '0))
        $info("a_en_matches_gnt pass at %0t", $time);
    else $error("a_en_matches_gnt failed at %0t", $time);

    a_grant_requested: assert property (@(posedge clk) disable iff (!rst) $rose(en) |-> req_q[gnt_id])
        $info("a_grant_requested pass at %0t", $time);
    else $error("a_grant_requested failed at %0t", $time);

    a_max_hold: assert property (@(posedge clk) disable iff (!rst)
        $rose(en) |-> en [*1:MAX_HOLD] ##1 !en)
        $info("a_max_hold pass at %0t", $time);
    else $error("a_max_hold failed at %0t", $time);

    a_idle_gap: assert property (@(posedge clk) disable iff (!rst) $fell(en) |=> !en)
        $info("a_idle_gap pass at %0t", $time);
    else $error("a_idle_gap failed at %0t", $time);

    a_timeout_cnt: assert property (@(posedge clk) disable iff (!rst)
        timeout |-> $past(cnt) == CNT_W'(MAX_HOLD - 1))
        $info("a_timeout_cnt pass at %0t", $time);
    else $error("a_timeout_cnt failed at %0t", $time);
`else
`endif

endmodule

// File: tb/tb_en_share_arbiter.sv
// Bench for en_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an ownership-level model.
module tb_en_share_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 8;
    localparam int ID_W     = $clog2(N_REQ);

    typedef enum {M_IDLE, M_OWN, M_GAP} mph_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ-1:0] done = '0;
    logic             en;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    mph_t m_ph    = M_IDLE;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_to    = 1'b0;
    bit   m_live  = 1'b0;

    en_share_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .en(en), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership-level reference: who owns the resource, how many cycles it has held it,
    // and where the next round-robin search starts.
    always @(posedge clk) begin : ref_model
        int   o, p, h, c;
        bit   found, to_n;
        mph_t phn;
        o = m_owner; p = m_ptr; h = m_held; phn = m_ph; to_n = 1'b0;
        if (!rst) begin
            phn = M_IDLE; o = 0; p = 0; h = 0;
        end else if (m_ph == M_OWN) begin
            h = h + 1;
            if (done[o] || !req[o]) begin
                phn = M_GAP; p = (o + 1) % N_REQ;
            end else if (h == MAX_HOLD) begin
                phn = M_GAP; to_n = 1'b1; p = (o + 1) % N_REQ;
            end
        end else if (req != '0) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                c = (p + k) % N_REQ;
                if (!found && req[c]) begin
                    found = 1'b1;
                    o = c;
                end
            end
            phn = M_OWN; h = 0;
        end else begin
            phn = M_IDLE;
        end
        m_ph <= phn; m_owner <= o; m_ptr <= p; m_held <= h; m_to <= to_n; m_live <= 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("model_en", en, (m_ph == M_OWN));
            checkOutput("model_gnt", gnt, (m_ph == M_OWN) ? (1 << m_owner) : 0);
            checkOutput("model_gnt_id", gnt_id, m_owner);
            checkOutput("model_busy", busy, (m_ph != M_IDLE));
            checkOutput("model_timeout", timeout, m_to);
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0; req = '0; done = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 5) == 0) done = gnt | N_REQ'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) done = N_REQ'($urandom_range(0, 15)) & ~gnt;
            else done = '0;
        end
        @(negedge clk);
        rst = 1'b1; req = '0; done = '0;
    endtask

    initial begin : main
        logic [N_REQ-1:0] rr_exp [10];
        int n;

        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

        // Reset values.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("reset_en", en, 0);
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_gnt_id", gnt_id, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_timeout", timeout, 0);

        // Single requester with done on the third grant cycle, then re-grant.
        req = 4'b0100;
        @(negedge clk); checkOutput("single_gnt1", gnt, 4'b0100);
        @(negedge clk);
        @(negedge clk); checkOutput("single_en3", en, 1); done = 4'b0100;
        @(negedge clk); checkOutput("single_rel_en", en, 0); checkOutput("single_rel_busy", busy, 1);
        checkOutput("single_rel_id", gnt_id, 2); done = '0;
        @(negedge clk); checkOutput("single_regnt", gnt, 4'b0100);
        req = '0;

        // Round robin, each owner releasing after one cycle.
        doReset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_gnt%0d", i), gnt, rr_exp[i]);
            done = gnt;
        end
        done = '0; req = '0;

        // Timeout: en high exactly MAX_HOLD cycles, then search resumes from owner+1.
        doReset();
        req = 4'b0010;
        n = 0;
        @(negedge clk);
        while (en && n < 3 * MAX_HOLD) begin
            n++;
            @(negedge clk);
        end
        checkOutput("timeout_en_cycles", n, 8);
        checkOutput("timeout_pulse", timeout, 1);
        req = 4'b0110;
        @(negedge clk);
        checkOutput("timeout_cleared", timeout, 0);
        checkOutput("timeout_next_owner", gnt, 4'b0100);
        req = '0;

        // done coinciding with the hold limit is a normal release.
        doReset();
        req = 4'b0001;
        repeat (8) @(negedge clk);
        checkOutput("coincide_en8", en, 1);
        done = 4'b0001;
        @(negedge clk);
        checkOutput("coincide_timeout", timeout, 0);
        checkOutput("coincide_en", en, 0);
        done = '0; req = '0;

        // done from a non-owner is ignored.
        doReset();
        req = 4'b0001;
        @(negedge clk); checkOutput("nonowner_gnt1", gnt, 4'b0001);
        done = 4'b0010;
        @(negedge clk);
        checkOutput("nonowner_gnt2", gnt, 4'b0001);
        checkOutput("nonowner_en", en, 1);
        done = '0; req = '0;

        // Reset in the middle of a grant.
        doReset();
        req = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_en", en, 0);
        checkOutput("midrst_gnt", gnt, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_regnt", gnt, 4'b0001);
        req = '0;

        doReset();
        applyStimulus(3000);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
